// File: rtl/ram_req_pkg.sv
// ram_req_pkg
// Shared types for the RAMsim_DPI request front-end: the buffered request
// record, the issue FSM state encoding, the address/data widths the request
// record is built from, and a helper that forms the response data word.
package ram_req_pkg;

  localparam int REQ_ADDR_W = 64;
  localparam int REQ_DATA_W = 64;

  typedef struct packed {
    logic                  we;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Writes return an all-zero data word; reads return what the RAM delivered.
  function automatic logic [REQ_DATA_W-1:0] rsp_data_sel(
    input logic                  we,
    input logic [REQ_DATA_W-1:0] rdata
  );
    logic [REQ_DATA_W-1:0] res;
    if (we) begin
      res = {REQ_DATA_W{1'b0}};
    end else begin
      res = rdata;
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_req_fifo.sv
// ram_req_fifo
// In-order synchronous FIFO of req_t records. Pointers are log2(DEPTH) bits
// and wrap naturally; a separate count distinguishes full from empty.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, din       write an entry (ignored when full)
//   pop, dout       drop the head entry (ignored when empty); dout shows head
//   full, empty     occupancy flags from the registered count
//   count           registered number of stored entries
module ram_req_fifo
  import ram_req_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  req_t                     din,
  input  logic                     pop,
  output req_t                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  req_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == {CNT_W{1'b0}});
  assign count     = count_q;
  assign dout      = mem_q[rd_ptr_q];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Next pointer and occupancy; simultaneous push and pop leave count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; not reset because the count decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/ram_req_queue.sv
// ram_req_queue
// Request front-end for RAMsim_DPI. Buffers core requests in an in-order FIFO,
// issues them one at a time to the RAM read or write port, waits for the
// matching finish and returns one registered response per request, in order.
// Optional feature macro: RAM_REQ_TIMEOUT_EN -- when defined, a wait longer
// than TIMEOUT cycles ends the request with rsp_err=1 and all-ones data.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   req_valid/req_ready/req_we/
//   req_addr/req_wdata                core request channel
//   rsp_valid/rsp_ready/rsp_we/
//   rsp_rdata/rsp_err                 core response channel (registered)
//   ram_rvalid/ram_raddr              RAM read issue (registered)
//   ram_wvalid/ram_waddr/ram_wdata    RAM write issue (registered)
//   ram_readReady/ram_writeReady      RAM accepts an issue
//   ram_readfin/ram_writefin/ram_rdata RAM completion and read data
module ram_req_queue
  import ram_req_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              ram_rvalid,
  output logic              ram_wvalid,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              ram_readReady,
  input  logic              ram_writeReady,
  input  logic              ram_readfin,
  input  logic              ram_writefin,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  // The request record is built from the package widths, so the port widths
  // must agree with them.
  if (ADDR_W != REQ_ADDR_W || DATA_W != REQ_DATA_W || DEPTH < 2 ||
      (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("ram_req_queue: unsupported parameter set");
  end

  state_t            state_q, state_d;
  logic              cur_we_q, cur_we_d;
  logic              ram_rvalid_q, ram_rvalid_d;
  logic              ram_wvalid_q, ram_wvalid_d;
  logic [ADDR_W-1:0] ram_raddr_q, ram_raddr_d;
  logic [ADDR_W-1:0] ram_waddr_q, ram_waddr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_we_q, rsp_we_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  req_t              push_rec_s;
  req_t              head_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic              fifo_pop_s;
  logic              ready_hit_s;
  logic              fin_hit_s;
  logic              timeout_s;

`ifdef RAM_REQ_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1'b1);
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             rsp_err_q, rsp_err_d;
  assign timeout_s = (timer_q == TMR_W'(TIMEOUT));
  assign rsp_err   = rsp_err_q;
`else
  assign timeout_s = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  assign push_rec_s = '{we: req_we, addr: req_addr, wdata: req_wdata};
  assign req_ready  = (fifo_count_s != CNT_W'(DEPTH));

  ram_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid & ~fifo_full_s),
    .din   (push_rec_s),
    .pop   (fifo_pop_s),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Only the port matching the working request's direction is watched.
  assign ready_hit_s = cur_we_q ? ram_writeReady : ram_readReady;
  assign fin_hit_s   = cur_we_q ? ram_writefin   : ram_readfin;

  // Issue FSM next state, RAM-side issue registers and response registers.
  always_comb begin
    state_d      = state_q;
    cur_we_d     = cur_we_q;
    ram_rvalid_d = ram_rvalid_q;
    ram_wvalid_d = ram_wvalid_q;
    ram_raddr_d  = ram_raddr_q;
    ram_waddr_d  = ram_waddr_q;
    ram_wdata_d  = ram_wdata_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_we_d     = rsp_we_q;
    rsp_rdata_d  = rsp_rdata_q;
    fifo_pop_s   = 1'b0;
`ifdef RAM_REQ_TIMEOUT_EN
    timer_d      = timer_q;
    rsp_err_d    = rsp_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          fifo_pop_s   = 1'b1;
          cur_we_d     = head_s.we;
          ram_rvalid_d = ~head_s.we;
          ram_wvalid_d = head_s.we;
          state_d      = ST_ISSUE;
`ifdef RAM_REQ_TIMEOUT_EN
          timer_d      = {TMR_W{1'b0}};
`endif
          if (head_s.we) begin
            ram_waddr_d = head_s.addr;
            ram_wdata_d = head_s.wdata;
          end else begin
            ram_raddr_d = head_s.addr;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE, ST_WAIT: begin
`ifdef RAM_REQ_TIMEOUT_EN
        timer_d = timer_q + TMR_ONE;
`endif
        // In WAIT the ready is irrelevant; only the finish matters.
        if ((state_q == ST_WAIT || ready_hit_s) && fin_hit_s) begin
          ram_rvalid_d = 1'b0;
          ram_wvalid_d = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_we_d     = cur_we_q;
          rsp_rdata_d  = rsp_data_sel(cur_we_q, ram_rdata);
          state_d      = ST_RESP;
`ifdef RAM_REQ_TIMEOUT_EN
          rsp_err_d    = 1'b0;
`endif
        end else if (state_q == ST_ISSUE && ready_hit_s) begin
          ram_rvalid_d = 1'b0;
          ram_wvalid_d = 1'b0;
          state_d      = ST_WAIT;
        end else if (timeout_s) begin
          ram_rvalid_d = 1'b0;
          ram_wvalid_d = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_we_d     = cur_we_q;
          rsp_rdata_d  = {DATA_W{1'b1}};
          state_d      = ST_RESP;
`ifdef RAM_REQ_TIMEOUT_EN
          rsp_err_d    = 1'b1;
`endif
        end else begin
          state_d = state_q;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and output registers; reset abandons any in-flight RAM transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cur_we_q     <= 1'b0;
      ram_rvalid_q <= 1'b0;
      ram_wvalid_q <= 1'b0;
      ram_raddr_q  <= {ADDR_W{1'b0}};
      ram_waddr_q  <= {ADDR_W{1'b0}};
      ram_wdata_q  <= {DATA_W{1'b0}};
      rsp_valid_q  <= 1'b0;
      rsp_we_q     <= 1'b0;
      rsp_rdata_q  <= {DATA_W{1'b0}};
`ifdef RAM_REQ_TIMEOUT_EN
      timer_q      <= {TMR_W{1'b0}};
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cur_we_q     <= cur_we_d;
      ram_rvalid_q <= ram_rvalid_d;
      ram_wvalid_q <= ram_wvalid_d;
      ram_raddr_q  <= ram_raddr_d;
      ram_waddr_q  <= ram_waddr_d;
      ram_wdata_q  <= ram_wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_we_q     <= rsp_we_d;
      rsp_rdata_q  <= rsp_rdata_d;
`ifdef RAM_REQ_TIMEOUT_EN
      timer_q      <= timer_d;
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  assign ram_rvalid = ram_rvalid_q;
  assign ram_wvalid = ram_wvalid_q;
  assign ram_raddr  = ram_raddr_q;
  assign ram_waddr  = ram_waddr_q;
  assign ram_wdata  = ram_wdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_we     = rsp_we_q;
  assign rsp_rdata  = rsp_rdata_q;

endmodule

// File: tb/tb_ram_req_queue.sv
// tb_ram_req_queue
// Self-checking bench for ram_req_queue: a behavioural RAM responder, a
// reference model of expected responses (memory contents in request order),
// and directed plus randomized steps in one initial block.
module tb_ram_req_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [63:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_we, rsp_err;
  logic [63:0] rsp_rdata;
  logic        ram_rvalid, ram_wvalid;
  logic [63:0] ram_raddr, ram_waddr, ram_wdata;
  logic        ram_readReady, ram_writeReady, ram_readfin, ram_writefin;
  logic [63:0] ram_rdata;

  ram_req_queue #(.DEPTH(4), .ADDR_W(64), .DATA_W(64), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_rvalid(ram_rvalid), .ram_wvalid(ram_wvalid),
    .ram_raddr(ram_raddr), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_readReady(ram_readReady), .ram_writeReady(ram_writeReady),
    .ram_readfin(ram_readfin), .ram_writefin(ram_writefin),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ---------------- behavioural RAM responder ----------------
  // slave_mode: 0 never ready, 1 always ready, 2 random ready
  int          slave_mode = 1;
  int          slave_dly = 1;
  bit          slave_dly_rand = 1'b0;
  bit          slave_busy = 1'b0;
  int          slave_cnt = 0;
  logic        slave_we = 1'b0;
  logic [63:0] slave_data = 64'd0;
  logic [63:0] ram_mem [logic [63:0]];

  always @(negedge clk) begin
    int d;
    bit rdy;
    ram_readReady  = 1'b0;
    ram_writeReady = 1'b0;
    ram_readfin    = 1'b0;
    ram_writefin   = 1'b0;
    ram_rdata      = 64'h5A5A_0000_A5A5_FFFF;
    rdy = (slave_mode == 1) || (slave_mode == 2 && $urandom_range(0, 1) == 1);
    if (slave_busy) begin
      if (slave_cnt <= 1) begin
        slave_busy = 1'b0;
        if (slave_we) ram_writefin = 1'b1;
        else begin ram_readfin = 1'b1; ram_rdata = slave_data; end
      end else begin
        slave_cnt = slave_cnt - 1;
      end
    end else if ((ram_rvalid === 1'b1 || ram_wvalid === 1'b1) && rdy) begin
      d = slave_dly_rand ? int'($urandom_range(0, 4)) : slave_dly;
      if (ram_wvalid === 1'b1) begin
        ram_writeReady = 1'b1;
        ram_mem[ram_waddr] = ram_wdata;
        slave_we = 1'b1;
      end else begin
        ram_readReady = 1'b1;
        slave_data = ram_mem.exists(ram_raddr) ? ram_mem[ram_raddr] : ~ram_raddr;
        slave_we = 1'b0;
      end
      if (d == 0) begin
        if (slave_we) ram_writefin = 1'b1;
        else begin ram_readfin = 1'b1; ram_rdata = slave_data; end
      end else begin
        slave_busy = 1'b1;
        slave_cnt = d;
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct { logic we; logic [63:0] rdata; } exp_t;
  exp_t        exp_q[$];
  logic [63:0] ref_mem [logic [63:0]];

  function automatic void model_push(input logic we, input logic [63:0] addr,
                                     input logic [63:0] wd);
    exp_t e;
    e.we = we;
    if (we) begin
      ref_mem[addr] = wd;
      e.rdata = 64'd0;
    end else begin
      e.rdata = ref_mem.exists(addr) ? ref_mem[addr] : ~addr;
    end
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare the presented response against the oldest expected one.
  task automatic chk_rsp(input string tag);
    chk({tag, "_have_exp"}, 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) begin
      chk({tag, "_we"}, 64'(rsp_we), 64'(exp_q[0].we));
      chk({tag, "_rdata"}, rsp_rdata, exp_q[0].rdata);
      chk({tag, "_err"}, 64'(rsp_err), 64'd0);
    end
  endtask

  // Called at a negedge: push one request once req_ready allows.
  task automatic push_req(input logic we, input logic [63:0] addr, input logic [63:0] wd);
    int cyc = 0;
    while (req_ready !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    if (req_ready === 1'b1) begin
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
      model_push(we, addr, wd);
      @(negedge clk);
      req_valid = 1'b0;
    end else begin
      chk("push_ready_timeout", 64'(req_ready), 64'd1);
    end
  endtask

  // Wait for a response, check it stays stable for 'hold' extra cycles, accept it.
  task automatic expect_rsp(input string tag, input int hold);
    int cyc = 0;
    rsp_ready = 1'b0;
    while (rsp_valid !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
    chk({tag, "_arrive"}, 64'(rsp_valid), 64'd1);
    if (rsp_valid === 1'b1) begin
      for (int i = 0; i <= hold; i++) begin
        chk_rsp(tag);
        if (i < hold) @(negedge clk);
      end
      rsp_ready = 1'b1;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  initial begin
    int cyc, n_push, n_rsp, seen_rsp, seen_iss;
    logic        rw;
    logic [63:0] a, wd;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 64'd0;
    req_wdata = 64'd0; rsp_ready = 1'b0;
    ram_mem[64'd13] = 64'hDEAD_BEEF;
    ref_mem[64'd13] = 64'hDEAD_BEEF;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_rsp_we", 64'(rsp_we), 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    chk("rst_ram_rvalid", 64'(ram_rvalid), 64'd0);
    chk("rst_ram_wvalid", 64'(ram_wvalid), 64'd0);
    chk("rst_ram_raddr", ram_raddr, 64'd0);
    chk("rst_ram_waddr", ram_waddr, 64'd0);
    chk("rst_ram_wdata", ram_wdata, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single read of address 13, finish 3 cycles after acceptance
    slave_mode = 1; slave_dly_rand = 1'b0; slave_dly = 3;
    push_req(1'b0, 64'd13, 64'd0);
    chk("lat_idle_rvalid", 64'(ram_rvalid), 64'd0);
    @(negedge clk);
    chk("lat_issue_rvalid", 64'(ram_rvalid), 64'd1);
    chk("lat_issue_raddr", ram_raddr, 64'd13);
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    chk("rd13_rsp_latency", 64'(cyc), 64'd4);
    expect_rsp("rd13", 0);

    // Write then read the same address
    slave_dly = 2;
    push_req(1'b1, 64'h40, 64'h1234);
    push_req(1'b0, 64'h40, 64'd0);
    expect_rsp("wr40", 0);
    expect_rsp("rd40", 0);

    // Fill with RAM and consumer both stalled
    slave_mode = 0;
    push_req(1'b0, 64'h100, 64'd0);
    push_req(1'b1, 64'h108, 64'hA1);
    push_req(1'b0, 64'h108, 64'd0);
    push_req(1'b1, 64'h110, 64'hB2);
    push_req(1'b0, 64'h110, 64'd0);
    chk("fill_req_ready", 64'(req_ready), 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("hold_rvalid", 64'(ram_rvalid), 64'd1);
      chk("hold_raddr", ram_raddr, 64'h100);
    end
    slave_mode = 1; slave_dly_rand = 1'b1;
    expect_rsp("drain0", 3);
    for (int i = 1; i < 5; i++) expect_rsp("drain", 0);
    chk("drain_req_ready", 64'(req_ready), 64'd1);

    // Reset while waiting for a finish; the late finish must be ignored
    slave_dly_rand = 1'b0; slave_dly = 20;
    push_req(1'b0, 64'h200, 64'd0);
    cyc = 0;
    while (!slave_busy && cyc < 20) begin @(negedge clk); cyc++; end
    chk("rst_mid_wait_accepted", 64'(slave_busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    seen_rsp = 0; seen_iss = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen_rsp++;
      if (ram_rvalid !== 1'b0 || ram_wvalid !== 1'b0) seen_iss++;
    end
    chk("rst_mid_no_rsp", 64'(seen_rsp), 64'd0);
    chk("rst_mid_no_issue", 64'(seen_iss), 64'd0);
    chk("rst_mid_req_ready", 64'(req_ready), 64'd1);
    chk("rst_mid_late_fin_sent", 64'(slave_busy), 64'd0);

    // Randomized traffic against the reference model
    slave_mode = 2; slave_dly_rand = 1'b1;
    n_push = 0; n_rsp = 0; cyc = 0;
    while (n_rsp < 60 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      if (rsp_valid === 1'b1 && $urandom_range(0, 3) != 0) begin
        chk_rsp("rand");
        rsp_ready = 1'b1;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        n_rsp++;
      end
      if (n_push < 60 && req_ready === 1'b1 && $urandom_range(0, 1) == 1) begin
        rw = 1'($urandom_range(0, 1));
        a  = 64'($urandom_range(0, 7)) << 3;
        wd = {32'($urandom), 32'($urandom)};
        req_valid = 1'b1; req_we = rw; req_addr = a; req_wdata = wd;
        model_push(rw, a, wd);
        n_push++;
      end
    end
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b0;
    chk("rand_all_responses", 64'(n_rsp), 64'd60);

`ifdef RAM_REQ_TIMEOUT_EN
    // Finish never arrives: error response 17 cycles after entering ISSUE
    repeat (10) @(negedge clk);
    slave_mode = 0;
    push_req(1'b0, 64'h77, 64'd0);
    @(negedge clk);
    chk("tmo_rvalid", 64'(ram_rvalid), 64'd1);
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    chk("tmo_latency", 64'(cyc), 64'd17);
    chk("tmo_err", 64'(rsp_err), 64'd1);
    chk("tmo_rdata", rsp_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("tmo_rvalid_dropped", 64'(ram_rvalid), 64'd0);
    rsp_ready = 1'b1;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    @(negedge clk);
    rsp_ready = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_req_queue.md
# ram_req_queue

Request front-end for the `RAMsim_DPI` memory model. It accepts read and write requests from a core over a valid/ready channel and buffers them in an in-order FIFO. It issues them one at a time to the RAM's separate read and write ports, waits for `readfin`/`writefin`, and returns one response per request, in order. It sits directly upstream of `RAMsim_DPI` and replaces the hand-driven `rvalid`/`raddr` stimulus in bench tops.

## Interface
Parameters:
- DEPTH, 4: request FIFO entries; power of two, ≥2.
- ADDR_W, 64: address width.
- DATA_W, 64: data width.
- TIMEOUT, 256: maximum cycles to wait for a finish; used only under the macro.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request FIFO can accept.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_we  out  1  echoes the request type.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  response ended by timeout.
- ram_rvalid / ram_wvalid  out  1  drive the RAM's `rvalid` / `wvalid`.
- ram_raddr / ram_waddr  out  ADDR_W  drive `raddr` / `waddr`.
- ram_wdata  out  DATA_W  drives `wdata`.
- ram_readReady / ram_writeReady  in  1  RAM accepts an issue.
- ram_readfin / ram_writefin  in  1  RAM finished the transaction.
- ram_rdata  in  DATA_W  RAM read data; valid when `ram_readfin` is high.

## Operation
- Push: occurs on an edge where `req_valid && req_ready`. `req_ready = (count != DEPTH)`, taken from the registered count. There is no push-through when full.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE → ISSUE: taken when the FIFO is non-empty. On this edge the head is popped into the working registers (we, addr, wdata).
- ISSUE: asserts `ram_rvalid` (read) or `ram_wvalid` (write) together with the address and data. These are held stable until the matching Ready is sampled high, then the FSM moves to WAIT.
- Same-cycle finish: if the matching fin is also high in the acceptance cycle, go directly to RESP. For a read, capture `ram_rdata` in that cycle.
- WAIT: on the matching fin, capture `ram_rdata` (read) or 0 (write) and go to RESP. Fins for the other direction are ignored.
- RESP: `rsp_valid = 1`. The response fields stay stable until `rsp_ready`. On an edge where `rsp_ready` is high, go to IDLE.
- Ordering: exactly one RAM transaction is outstanding at a time, so responses are strictly in request order.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. Push and pop in the same edge are legal at any non-full count.

## Timing
- Reset values, effective on the edge after `rst` is sampled high:
  - FSM in IDLE, FIFO count 0, `req_ready=1`.
  - `rsp_valid=0`, `rsp_err=0`, `rsp_we=0`, `rsp_rdata=0`.
  - `ram_rvalid=0`, `ram_wvalid=0`; RAM address and data outputs 0.
- Reset mid-operation: any in-flight RAM transaction is abandoned and a late fin after reset is ignored.
- Issue latency: a request pushed on edge E0 enters ISSUE on E1. The RAM valid is high in the cycle after E1. Queued requests follow back-to-back with a one-cycle IDLE between them.
- Response latency: `rsp_valid` rises on the edge after the fin is sampled.
- All outputs are registered; there is no combinational path from RAM inputs to core outputs.

## Configuration
- `RAM_REQ_TIMEOUT_EN` defined:
  - A cycle counter runs in ISSUE and WAIT and clears on entry to ISSUE.
  - If it reaches TIMEOUT, go to RESP with `rsp_err=1` and `rsp_rdata` all ones.
- `RAM_REQ_TIMEOUT_EN` undefined:
  - There is no counter and the FSM waits indefinitely.
  - `rsp_err` is tied to 0.

## Structure
- Package `ram_req_pkg`: the `req_t` struct {we, addr, wdata}, the FSM state enum, and the address and data width localparams.
- Sub-module `ram_req_fifo`: a synchronous FIFO of `req_t` with push/pop/full/empty/count.
- The FSM and RAM-side registers live in `ram_req_queue`.

## Test plan
- Single read: push read addr 13; RAM holds Ready=1 and raises readfin 3 cycles later with rdata 0xDEAD_BEEF → `rsp_valid` with `rsp_we=0`, `rsp_rdata=0xDEADBEEF`, `rsp_err=0`.
- Write then read, same address 0x40, wdata 0x1234 → two in-order responses: write first (`rsp_we=1`, rdata 0), then read returning 0x1234.
- Fill: hold rsp_ready=0 and Ready=0, push 5 requests with DEPTH=4 → head popped into ISSUE, 4 more fill the FIFO, `req_ready=0`; releasing drains all 5 in order.
- Backpressure: hold ISSUE with Ready=0 for 10 cycles → `ram_rvalid` and `ram_raddr` stay constant; hold RESP with rsp_ready=0 → response stays stable.
- Reset mid-WAIT: assert `rst` one cycle, then pulse readfin → no response, FIFO empty, all valids low.
- With `RAM_REQ_TIMEOUT_EN` and TIMEOUT=16: fin never arrives → `rsp_err=1`, `rsp_rdata=0xFFFF_FFFF_FFFF_FFFF` 17 cycles after entering ISSUE.
